// File: rtl/shifter_if.sv
// Mode, serial/parallel data and register-contents bundle for the universal shift register.
// The master drives the controls and observes out. The slave owns the register and drives out.
interface shifter_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       S;
  logic             IR;
  logic             IL;
  logic [WIDTH-1:0] In;
  logic [WIDTH-1:0] out;

  modport master (output S, output IR, output IL, output In, input out);
  modport slave  (input S, input IR, input IL, input In, output out);
endinterface

// File: rtl/shifter.sv
// 74x194-style universal shift register: hold, shift right, shift left, parallel load.
// The result appears on out after the same rising edge. There is no backpressure: one operation per clock.
module shifter #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  shifter_if.slave bus
);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("shifter: WIDTH must be >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] q;

  // Bits shifted off the end are dropped, and the vacated bit takes the serial input for that direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      case (bus.S)
        2'b01:   q <= {bus.IR, q[WIDTH-1:1]};
        2'b10:   q <= {q[WIDTH-2:0], bus.IL};
        2'b11:   q <= bus.In;
        default: q <= q;
      endcase
    end
  end

  assign bus.out = q;

endmodule

// File: tb/tb_shifter.sv
// Directed and random checks of the shift register against a scoreboard of expected contents.
module tb_shifter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] model = 8'h00;
  logic [7:0] sb[$];

  shifter_if #(.WIDTH(8)) bus ();

  shifter #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag);
    logic [7:0] exp;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, bus.out);
    end else begin
      exp = sb.pop_front();
      assert (bus.out === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, bus.out, exp);
      end
    end
  endtask

  // Drive one operation, predict its result, then compare just after the edge.
  task automatic step(input logic [1:0] s, input logic ir, input logic il,
                      input logic [7:0] din, input string tag);
    bus.S  = s;
    bus.IR = ir;
    bus.IL = il;
    bus.In = din;
    case (s)
      2'b01:   model = {ir, model[7:1]};
      2'b10:   model = {model[6:0], il};
      2'b11:   model = din;
      default: model = model;
    endcase
    sb.push_back(model);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic reset_low(input string tag);
    reset = 1'b0;
    #1;
    model = 8'h00;
    sb.push_back(model);
    check(tag);
  endtask

  initial begin
    logic [7:0] exp_v;
    logic [1:0] rs;
    logic       rir;
    logic       ril;
    logic [7:0] rin;

    reset  = 1'b0;
    bus.S  = 2'b00;
    bus.IR = 1'b0;
    bus.IL = 1'b0;
    bus.In = 8'h00;
    @(posedge clk);
    #1;
    sb.push_back(8'h00);
    check("reset_initial");

    // Test 1: an asynchronous clear from A5, then edges while reset is held low are ignored.
    reset = 1'b1;
    step(2'b11, 1'b0, 1'b0, 8'hA5, "preload_a5");
    reset_low("async_clear");
    bus.S  = 2'b11;
    bus.In = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      sb.push_back(8'h00);
      check("held_in_reset");
    end
    reset = 1'b1;

    // Test 2: load, then hold while the other inputs toggle.
    step(2'b11, 1'b0, 1'b0, 8'h3C, "load_3c");
    for (int i = 0; i < 5; i++) begin
      step(2'b00, i[0], ~i[0], 8'hFF ^ 8'(i), "hold");
    end

    // Test 3: shift right.
    step(2'b11, 1'b0, 1'b0, 8'h81, "load_81_r");
    step(2'b01, 1'b1, 1'b0, 8'h00, "shr_c0");
    step(2'b01, 1'b0, 1'b1, 8'h00, "shr_60");
    step(2'b01, 1'b0, 1'b1, 8'h00, "shr_30");
    exp_v = 8'h30;
    checks++;
    assert (model === exp_v)
    else begin
      failures++;
      $error("FAIL shr_model observed=%h expected=%h", model, exp_v);
    end

    // Test 4: shift left.
    step(2'b11, 1'b0, 1'b0, 8'h81, "load_81_l");
    step(2'b10, 1'b1, 1'b0, 8'h00, "shl_02");
    step(2'b10, 1'b0, 1'b1, 8'h00, "shl_05");
    step(2'b10, 1'b0, 1'b1, 8'h00, "shl_0b");

    // Test 5: fill with ones from the LSB, then drain with zeros from the MSB.
    step(2'b11, 1'b0, 1'b0, 8'h00, "load_00");
    for (int i = 0; i < 8; i++) step(2'b10, 1'b0, 1'b1, 8'h00, "fill_left");
    for (int i = 0; i < 8; i++) step(2'b01, 1'b0, 1'b1, 8'h00, "drain_right");

    // Test 6: a reset in mid-operation, the first edge after release, then random traffic.
    step(2'b11, 1'b0, 1'b0, 8'hF0, "load_f0");
    bus.S = 2'b01;
    reset_low("mid_op_clear");
    #2;
    reset = 1'b1;
    step(2'b01, 1'b1, 1'b0, 8'h00, "release_shr_80");
    for (int i = 0; i < 30; i++) begin
      rs  = 2'($urandom_range(0, 3));
      rir = 1'($urandom);
      ril = 1'($urandom);
      rin = 8'($urandom);
      step(rs, rir, ril, rin, "random");
    end

    checks++;
    assert (sb.size() == 0)
    else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
